// File: rtl/hdr_pkg.sv
// Shared types for the HDR exposure splitter: FSM states and the line-buffer
// address width derived from the line length.
package hdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAIR
  } hdr_state_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One-line pixel store: simple dual-port, write port plus registered read port.
// Contents and read register are deliberately left without reset.
module line_buffer_ram
  import hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 1920,
  parameter int unsigned ADDR_WIDTH = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hdr_exposure_splitter.sv
// Splits a line-interleaved long/short exposure stream into two pixel-aligned
// streams: even lines are buffered, odd lines are paired with them on output.
module hdr_exposure_splitter
  import hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 1920
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  asi_snk_valid_i,
  output logic                  asi_snk_ready_o,
  input  logic [DATA_WIDTH-1:0] asi_snk_data_i,
  input  logic                  asi_snk_startofpacket_i,
  input  logic                  asi_snk_endofpacket_i,
  output logic                  aso_src_0_valid_o,
  input  logic                  aso_src_0_ready_i,
  output logic [DATA_WIDTH-1:0] aso_src_0_data_o,
  output logic                  aso_src_0_startofpacket_o,
  output logic                  aso_src_0_endofpacket_o,
  output logic                  aso_src_1_valid_o,
  input  logic                  aso_src_1_ready_i,
  output logic [DATA_WIDTH-1:0] aso_src_1_data_o,
  output logic                  aso_src_1_startofpacket_o,
  output logic                  aso_src_1_endofpacket_o
);

  localparam int unsigned   AW       = addr_w(LINE_WIDTH);
  localparam logic [AW-1:0] PIX_LAST = AW'(LINE_WIDTH - 1);

  hdr_state_t            state, state_nx;
  logic [AW-1:0]         pix;
  logic                  parity;
  logic                  ready_en;
  logic                  first_pair;
  logic                  out_valid, out_sop, out_eop_q;
  logic [DATA_WIDTH-1:0] src1_data, rd_data;
  logic                  snk_ready, accept, xfer, line_end, abandon_req;
  logic                  wr_en, rd_en, restart;
  logic [AW-1:0]         wr_addr;

  assign xfer      = out_valid & aso_src_0_ready_i & aso_src_1_ready_i;
  assign snk_ready = ready_en & ((state != ST_PAIR) | ~out_valid | xfer);
  assign accept    = asi_snk_valid_i & snk_ready;
  assign line_end  = (pix == PIX_LAST);
  assign wr_addr   = restart ? '0 : pix;
  // A sop arriving mid-frame closes the pair currently on the outputs.
  assign abandon_req = ready_en & asi_snk_valid_i & asi_snk_startofpacket_i &
                       (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    restart  = 1'b0;
    if (accept && asi_snk_startofpacket_i) begin
      restart  = 1'b1;
      wr_en    = 1'b1;
      state_nx = asi_snk_endofpacket_i ? ST_IDLE : ST_FILL;
    end else if (accept) begin
      unique case (state)
        ST_IDLE: state_nx = ST_IDLE;
        ST_FILL: begin
          if (asi_snk_endofpacket_i) begin
            state_nx = ST_IDLE;
          end else begin
            wr_en = 1'b1;
            if (line_end && !parity) state_nx = ST_PAIR;
          end
        end
        ST_PAIR: begin
          rd_en = 1'b1;
          if (asi_snk_endofpacket_i)  state_nx = ST_IDLE;
          else if (line_end && parity) state_nx = ST_FILL;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix    <= '0;
      parity <= 1'b0;
    end else if (accept) begin
      if (restart) begin
        pix    <= AW'(1);
        parity <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (asi_snk_endofpacket_i) begin
          pix    <= '0;
          parity <= 1'b0;
        end else if (line_end) begin
          pix    <= '0;
          parity <= ~parity;
        end else begin
          pix <= pix + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop_q  <= 1'b0;
      src1_data  <= '0;
      first_pair <= 1'b0;
    end else begin
      if (restart)    first_pair <= 1'b1;
      else if (rd_en) first_pair <= 1'b0;

      if (rd_en) begin
        out_valid <= 1'b1;
        src1_data <= asi_snk_data_i;
        out_sop   <= first_pair;
        out_eop_q <= asi_snk_endofpacket_i;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop_q <= 1'b0;
      end else if (out_valid && abandon_req) begin
        out_eop_q <= 1'b1;
      end
    end
  end

  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LINE_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (asi_snk_data_i),
    .rd_en   (rd_en),
    .rd_addr (pix),
    .rd_data (rd_data)
  );

  assign asi_snk_ready_o           = snk_ready;
  assign aso_src_0_valid_o         = out_valid;
  assign aso_src_1_valid_o         = out_valid;
  assign aso_src_0_data_o          = out_valid ? rd_data : '0;
  assign aso_src_1_data_o          = src1_data;
  assign aso_src_0_startofpacket_o = out_sop;
  assign aso_src_1_startofpacket_o = out_sop;
  assign aso_src_0_endofpacket_o   = out_eop_q | (out_valid & abandon_req);
  assign aso_src_1_endofpacket_o   = out_eop_q | (out_valid & abandon_req);

endmodule

// File: tb/tb_hdr_exposure_splitter.sv
// Scoreboard bench for hdr_exposure_splitter with LINE_WIDTH=4: a line-level
// frame model queues expected pairs, a monitor checks every completed transfer.
module tb_hdr_exposure_splitter;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;

  typedef struct {
    logic [DW-1:0] d;
    bit            s;
    bit            e;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    bit            s;
    bit            e;
    bit            b2b;
  } pair_t;

  typedef beat_t beat_q_t[$];

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          snk_valid = 1'b0;
  logic          snk_sop   = 1'b0;
  logic          snk_eop   = 1'b0;
  logic [DW-1:0] snk_data  = '0;
  logic          snk_ready;
  logic          v0, v1, s0, s1, e0, e1, r0, r1;
  logic [DW-1:0] d0, d1;
  logic          rr0 = 1'b1;
  logic          rr1 = 1'b1;

  int unsigned     rdy_mode = 0;  // 0: both high, 1: random, 2: src1 held low
  int unsigned     checks   = 0;
  int unsigned     errors   = 0;
  longint unsigned cyc      = 0;
  pair_t           exp_q[$];

  assign r0 = (rdy_mode == 1) ? rr0 : 1'b1;
  assign r1 = (rdy_mode == 1) ? rr1 : (rdy_mode != 2);

  hdr_exposure_splitter #(
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .asi_snk_valid_i           (snk_valid),
    .asi_snk_ready_o           (snk_ready),
    .asi_snk_data_i            (snk_data),
    .asi_snk_startofpacket_i   (snk_sop),
    .asi_snk_endofpacket_i     (snk_eop),
    .aso_src_0_valid_o         (v0),
    .aso_src_0_ready_i         (r0),
    .aso_src_0_data_o          (d0),
    .aso_src_0_startofpacket_o (s0),
    .aso_src_0_endofpacket_o   (e0),
    .aso_src_1_valid_o         (v1),
    .aso_src_1_ready_i         (r1),
    .aso_src_1_data_o          (d1),
    .aso_src_1_startofpacket_o (s1),
    .aso_src_1_endofpacket_o   (e1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rr0 <= ($urandom_range(0, 3) != 0);
    rr1 <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected output of one frame: every odd-line pixel pairs with the pixel of
  // the preceding even line at the same column.
  task automatic model_frame(input beat_t f[$], input bit abandoned, input bit contig);
    pair_t       loc[$];
    pair_t       p;
    bit          first = 1'b1;
    int unsigned n = f.size();
    for (int unsigned j = 0; j < n; j++) begin
      if (((j / LW) % 2) == 1) begin
        p.d0  = f[j - LW].d;
        p.d1  = f[j].d;
        p.s   = first;
        p.e   = f[j].e;
        p.b2b = contig && ((j % LW) != 0);
        first = 1'b0;
        loc.push_back(p);
      end
    end
    if (abandoned && n > 0 && (((n - 1) / LW) % 2) == 1) begin
      p   = loc.pop_back();
      p.e = 1'b1;
      loc.push_back(p);
    end
    foreach (loc[i]) exp_q.push_back(loc[i]);
  endtask

  function automatic beat_q_t ramp_frame(input logic [DW-1:0] base, input int unsigned len,
                                         input bit with_eop);
    beat_q_t q;
    beat_t   b;
    for (int unsigned i = 0; i < len; i++) begin
      b.d = base + DW'(i);
      b.s = (i == 0);
      b.e = with_eop && (i == len - 1);
      q.push_back(b);
    end
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] d, input bit s, input bit e);
    bit          done = 1'b0;
    int unsigned n    = 0;
    snk_valid = 1'b1;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    while (!done) begin
      @(negedge clk);
      done = snk_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        chk("sink_accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic send_frame(input beat_t f[$], input bit gaps);
    foreach (f[j]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(f[j].d, f[j].s, f[j].e);
    end
  endtask

  // Monitor: pops one expected pair per completed transfer.
  logic [DW-1:0]   h0, h1;
  logic            hs;
  bit              hold = 1'b0;
  longint unsigned last_x = 0;

  always @(negedge clk) begin
    pair_t p;
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (v0 || v1) chk("valid_pair", 64'({v0, s0, e0}), 64'({v1, s1, e1}));
      if (hold) chk("hold_stable", 64'({v0, d0, d1, s0}), 64'({1'b1, h0, h1, hs}));
      if (v0 && r0 && r1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 64'({d0, d1}), 64'(0));
        end else begin
          p = exp_q.pop_front();
          chk("pair", 64'({d0, d1, s0, s1, e0, e1}), 64'({p.d0, p.d1, p.s, p.s, p.e, p.e}));
          if (p.b2b) chk("back_to_back", 64'(cyc - last_x), 64'(1));
        end
        last_x = cyc;
        hold   = 1'b0;
      end else if (v0) begin
        hold = 1'b1;
        h0   = d0;
        h1   = d1;
        hs   = s0;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beat_q_t     fa, fb, fp;
    beat_t       b;
    int unsigned n;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(snk_ready), 64'(0));
    chk("rst_outputs", 64'({v0, v1, s0, s1, e0, e1, d0, d1}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(snk_ready), 64'(1));

    // Basic four-line frame, readies high.
    fa = ramp_frame(16'h0100, 16, 1'b1);
    model_frame(fa, 1'b0, 1'b1);
    send_frame(fa, 1'b0);

    // Stray beats before sop are dropped.
    send_beat(16'hDEAD, 1'b0, 1'b0);
    send_beat(16'hBEEF, 1'b0, 1'b1);
    send_beat(16'h0BAD, 1'b0, 1'b0);
    model_frame(fa, 1'b0, 1'b1);
    send_frame(fa, 1'b0);

    // src1 stalls for 3 cycles with a pair pending mid odd line.
    fa = ramp_frame(16'h0300, 16, 1'b1);
    model_frame(fa, 1'b0, 1'b0);
    for (int unsigned j = 0; j < 6; j++) send_beat(fa[j].d, fa[j].s, fa[j].e);
    rdy_mode  = 2;
    snk_valid = 1'b1;
    snk_data  = fa[6].d;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 64'(snk_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    for (int unsigned j = 6; j < 16; j++) send_beat(fa[j].d, fa[j].s, fa[j].e);

    // New sop at pixel 2 of line 1 abandons the frame.
    fa = ramp_frame(16'h0200, 6, 1'b0);
    fb = ramp_frame(16'h0400, 16, 1'b1);
    model_frame(fa, 1'b1, 1'b1);
    model_frame(fb, 1'b0, 1'b1);
    send_frame(fa, 1'b0);
    send_frame(fb, 1'b0);

    // eop at the end of line 0: nothing emitted, back to idle.
    fa = ramp_frame(16'h0500, 4, 1'b1);
    model_frame(fa, 1'b0, 1'b1);
    send_frame(fa, 1'b0);
    send_beat(16'h0666, 1'b0, 1'b0);
    fb = ramp_frame(16'h0600, 16, 1'b1);
    model_frame(fb, 1'b0, 1'b1);
    send_frame(fb, 1'b0);

    // Reset mid-PAIR: the pair of the last accepted beat is lost.
    fa = ramp_frame(16'h0700, 6, 1'b0);
    fp = ramp_frame(16'h0700, 5, 1'b0);
    model_frame(fp, 1'b0, 1'b1);
    send_frame(fa, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({v0, v1, s0, s1, e0, e1, d0, d1}), 64'(0));
    chk("midrst_ready", 64'(snk_ready), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midrst", 64'(snk_ready), 64'(1));
    fb = ramp_frame(16'h0800, 16, 1'b1);
    model_frame(fb, 1'b0, 1'b1);
    send_frame(fb, 1'b0);

    // Randomized frames with random gaps and output back-pressure.
    rdy_mode = 1;
    for (int unsigned k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 2)) send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 14);
      fa.delete();
      for (int unsigned i = 0; i < n; i++) begin
        b.d = DW'($urandom);
        b.s = (i == 0);
        b.e = (i == n - 1);
        fa.push_back(b);
      end
      model_frame(fa, 1'b0, 1'b0);
      send_frame(fa, 1'b1);
    end

    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("pairs_outstanding", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdr_exposure_splitter.md
HDR_EXPOSURE_SPLITTER -- requirements
Module: hdr_exposure_splitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning pixel word width (Y/CrCb 8+8).
REQ-002 SHALL have parameter LINE_WIDTH, default 1920, meaning pixels per line.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have sink ports asi_snk_valid_i in 1, asi_snk_ready_o out 1, asi_snk_data_i in DATA_WIDTH, asi_snk_startofpacket_i in 1, asi_snk_endofpacket_i in 1: one interleaved-exposure frame per packet.
REQ-006 SHALL have, for k = 0 and 1, source ports aso_src_k_valid_o out 1, aso_src_k_ready_i in 1, aso_src_k_data_o out DATA_WIDTH, aso_src_k_startofpacket_o out 1, aso_src_k_endofpacket_o out 1; k=0 carries the long exposure, k=1 the short exposure.

Function
REQ-007 SHALL treat input lines as alternating: even lines (0,2,..) long exposure, odd lines short; line boundary every LINE_WIDTH accepted beats.
REQ-008 SHALL implement states IDLE, FILL, PAIR; IDLE->FILL on an accepted beat with sop; FILL->PAIR after beat LINE_WIDTH-1 of an even line; PAIR->FILL after beat LINE_WIDTH-1 of an odd line without eop; PAIR->IDLE on an accepted beat with eop.
REQ-009 SHALL, in IDLE, drive asi_snk_ready_o=1 and discard beats without sop.
REQ-010 SHALL, in FILL, drive asi_snk_ready_o=1 and write each beat into the line buffer at the pixel-counter address; no source output.
REQ-011 SHALL, in PAIR, drive asi_snk_ready_o = ~out_valid | (aso_src_0_ready_i & aso_src_1_ready_i).
REQ-012 SHALL, one cycle after a PAIR beat is accepted, present buffered pixel n on aso_src_0_data_o and odd-line pixel n on aso_src_1_data_o, both valids asserted together.
REQ-013 SHALL complete a pair transfer only when both readies are high in the same cycle; valids, data, sop, eop held stable until then.
REQ-014 SHALL assert both output sop on the first pair of a frame and both output eop on the pair produced from the input eop beat.
REQ-015 SHALL count pixels 0..LINE_WIDTH-1, wrapping to 0 at each line end; a parity bit tracks even/odd line.
REQ-016 SHALL, on an accepted sop beat in FILL or PAIR, abandon the current frame (pending output pair still delivered with eop forced 1), reset counter and parity, and restart FILL with that beat as pixel 0.
REQ-017 SHALL, on eop accepted in FILL, drop the buffered line, emit nothing, and go to IDLE.
REQ-018 SHALL, on eop in PAIR before pixel LINE_WIDTH-1, emit that pair with eop and go to IDLE.
REQ-019 SHALL sustain one pair per cycle in PAIR with both readies held high.

Reset
REQ-020 SHALL, while reset_n=0, set state IDLE, counter 0, parity 0, all aso_* valid/sop/eop 0, data 0, asi_snk_ready_o 0.
REQ-021 SHALL drive asi_snk_ready_o=1 on the first cycle after reset_n deassertion; reset mid-frame discards all buffered data.

Structure
REQ-022 SHALL take the state enum and LINE_WIDTH-derived address width ($clog2) from shared package hdr_pkg.
REQ-023 SHALL instantiate one sub-module line_buffer_ram: simple dual-port, LINE_WIDTH x DATA_WIDTH, 1-cycle registered read, no reset on contents.

Verification (LINE_WIDTH=4)
REQ-024 Frame of 4 lines, pixels 0x0100+i, readies high -> src0 emits 0x0100..03 then 0x0108..0B, src1 0x0104..07 then 0x010C..0F; sop on first pair, eop on last, 1 pair/cycle in PAIR.
REQ-025 aso_src_1_ready_i low 3 cycles mid-odd-line -> no pair lost/duplicated, asi_snk_ready_o low while pair pending, data stable.
REQ-026 Beats before sop -> discarded; output identical to REQ-024.
REQ-027 sop at pixel 2 of line 1 -> old pair delivered with eop=1, new frame pairs correct.
REQ-028 eop at line 0 pixel 3 -> no output, state IDLE; reset_n pulse mid-PAIR -> all valids 0 immediately, next frame correct.
